// File: rtl/graphics_pkg.sv
// Shared fp32 vector and matrix types for the geometry front end.
package graphics_pkg;

  localparam logic [31:0] FP32_ONE  = 32'h3F800000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

  typedef logic [2:0][31:0]      vec3_t;
  typedef logic [3:0][31:0]      vec4_t;
  typedef logic [3:0][3:0][31:0] mat4_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_OUTPUT  = 2'd3
  } vt_state_t;

endpackage

// File: rtl/fp32_dot.sv
// Four-element fp32 dot product: c = a0*b0 + a1*b1 + a2*b2 + a3*b3.
// Latency is 4 cycles from valid_in to valid_out. Denormals flush to zero,
// rounding is round-to-nearest-even, and NaN/Inf follow IEEE-754 rules.
module fp32_dot
  import graphics_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [3:0][31:0] a_in,
  input  logic [3:0][31:0] b_in,
  output logic             valid_out,
  output logic [31:0]      c_out
);

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [7:0]        ea, eb;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       m;
    logic              g, st;
    logic [24:0]       r;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if ((ea == 8'hFF && a[22:0] != '0) || (eb == 8'hFF && b[22:0] != '0)) return FP32_QNAN;
    if (ea == 8'hFF || eb == 8'hFF) begin
      if (ea == 8'h00 || eb == 8'h00) return FP32_QNAN;
      return {s, 8'hFF, 23'd0};
    end
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    r = {2'b01, m} + {24'd0, g & (st | m[0])};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 10'sd0)   return {s, 31'd0};
    return {s, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my;
    logic [27:0]       sum;
    logic              st;
    logic signed [9:0] e;
    logic [24:0]       r;
    logic              a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    if (a_nan || b_nan) return FP32_QNAN;
    if (a_inf && b_inf && (a[31] != b[31])) return FP32_QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'd0} : b;
    if (b[30:23] == 8'h00) return a;
    // Order by magnitude so the aligned subtraction never goes negative
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    st = 1'b0;
    for (int i = 0; i < 27; i++)
      if (i < int'(d)) st = st | my[i];
    my    = my >> d;
    my[0] = my[0] | st;
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, my};
    else                sum = {1'b0, mx} - {1'b0, my};
    if (sum == '0) return 32'd0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++)
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 10'sd1;
        end
    end
    r = {1'b0, sum[26:3]} + {24'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 10'sd0)   return {x[31], 31'd0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

  vec4_t             a_p0, b_p0;
  vec4_t             prod_p1;
  logic [31:0]       s01_p2, s23_p2;
  logic [31:0]       c_p3;
  logic              vld_p0, vld_p1, vld_p2, vld_p3;

  // Valid shift register; clearing it on reset drops any result in flight
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p0 <= valid_in;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Stage p0: operand capture
  always_ff @(posedge clk_in) begin
    if (valid_in) begin
      a_p0 <= a_in;
      b_p0 <= b_in;
    end
  end

  // Stage p1: four element products
  always_ff @(posedge clk_in) begin
    if (vld_p0)
      for (int k = 0; k < 4; k++) prod_p1[k] <= fp_mul(a_p0[k], b_p0[k]);
  end

  // Stage p2: pairwise sums
  always_ff @(posedge clk_in) begin
    if (vld_p1) begin
      s01_p2 <= fp_add(prod_p1[0], prod_p1[1]);
      s23_p2 <= fp_add(prod_p1[2], prod_p1[3]);
    end
  end

  // Stage p3: final sum
  always_ff @(posedge clk_in) begin
    if (vld_p2) c_p3 <= fp_add(s01_p2, s23_p2);
  end

  assign valid_out = vld_p3;
  assign c_out     = c_p3;

endmodule

// File: rtl/vertex_transform.sv
// Multiplies object-space vertices by a double-buffered 4x4 view-projection
// matrix, one row per cycle through a shared fp32 dot-product pipeline.
module vertex_transform
  import graphics_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             mat_valid_in,
  input  logic [3:0][31:0] mat_col_in,
  input  logic             vertex_valid_in,
  input  logic [2:0][31:0] vertex_in,
  output logic             vertex_ready_out,
  output logic             valid_out,
  output logic [3:0][31:0] vertex_out,
  input  logic             ready_in
);

  vt_state_t   state;
  logic [1:0]  col_idx;
  logic [1:0]  row_idx;
  logic        commit_pending;
  logic        matrix_loaded;
  logic        commit_now;
  logic        accept;
  mat4_t       shadow, shadow_next, active;
  vec4_t       b_vec, a_row;
  logic        dot_valid_in, dot_valid_out;
  logic [31:0] dot_c;

  assign vertex_ready_out = (state == ST_IDLE) && matrix_loaded;
  assign accept           = vertex_valid_in && vertex_ready_out;
  assign dot_valid_in     = (state == ST_ISSUE);
  // A commit waits for Idle so an in-flight transform keeps its matrix
  assign commit_now       = (state == ST_IDLE) &&
                            (commit_pending || (mat_valid_in && col_idx == 2'd3));

  // Shadow bank with this cycle's beat merged, so a same-cycle commit sees it
  always_comb begin
    shadow_next = shadow;
    if (mat_valid_in) shadow_next[col_idx] = mat_col_in;
  end

  // Gather row row_idx of the active bank across its four columns
  always_comb begin
    a_row = '0;
    for (int c = 0; c < 4; c++) a_row[c] = active[c][row_idx];
  end

  // Matrix banks; left unreset because matrix_loaded gates their use
  always_ff @(posedge clk_in) begin
    shadow <= shadow_next;
    if (commit_now) active <= shadow_next;
  end

  // Column counter, pending commit and loaded flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col_idx        <= 2'd0;
      commit_pending <= 1'b0;
      matrix_loaded  <= 1'b0;
    end else begin
      if (mat_valid_in) col_idx <= col_idx + 2'd1;
      if (commit_now) begin
        commit_pending <= 1'b0;
        matrix_loaded  <= 1'b1;
      end else if (mat_valid_in && col_idx == 2'd3) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Homogeneous input vector latched at acceptance
  always_ff @(posedge clk_in) begin
    if (accept) b_vec <= {FP32_ONE, vertex_in[2], vertex_in[1], vertex_in[0]};
  end

  // Transform sequencer: issue four rows, collect four results, hold output
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      row_idx    <= 2'd0;
      valid_out  <= 1'b0;
      vertex_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            row_idx <= 2'd0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          row_idx <= row_idx + 2'd1;
          if (row_idx == 2'd3) state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (dot_valid_out) begin
            vertex_out[row_idx] <= dot_c;
            row_idx             <= row_idx + 2'd1;
            if (row_idx == 2'd3) begin
              valid_out <= 1'b1;
              state     <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fp32_dot u_dot (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .valid_in  (dot_valid_in),
    .a_in      (a_row),
    .b_in      (b_vec),
    .valid_out (dot_valid_out),
    .c_out     (dot_c)
  );

endmodule

// File: tb/tb_vertex_transform.sv
// Scenario bench for vertex_transform with an expected-result queue.
`timescale 1ns/1ps
module tb_vertex_transform;
  import graphics_pkg::*;

  localparam int L_DOT = 4;          // fp32_dot pipeline depth
  localparam int LAT   = 5 + L_DOT;  // acceptance to valid_out

  localparam logic [31:0] F0 = 32'h00000000;
  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;
  localparam logic [31:0] F5 = 32'h40A00000;
  localparam logic [31:0] F6 = 32'h40C00000;
  localparam logic [31:0] F7 = 32'h40E00000;

  logic             clk = 1'b0;
  logic             rst_in, mat_valid_in, vertex_valid_in, ready_in;
  logic             vertex_ready_out, valid_out;
  logic [3:0][31:0] mat_col_in, vertex_out;
  logic [2:0][31:0] vertex_in;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  vec4_t exp_q[$];

  vertex_transform dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .mat_valid_in     (mat_valid_in),
    .mat_col_in       (mat_col_in),
    .vertex_valid_in  (vertex_valid_in),
    .vertex_in        (vertex_in),
    .vertex_ready_out (vertex_ready_out),
    .valid_out        (valid_out),
    .vertex_out       (vertex_out),
    .ready_in         (ready_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec4_t mk4(input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] z, input logic [31:0] w);
    return {w, z, y, x};
  endfunction

  function automatic vec3_t mk3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  function automatic mat4_t diag(input logic [31:0] s);
    mat4_t m;
    m[0] = mk4(s, F0, F0, F0);
    m[1] = mk4(F0, s, F0, F0);
    m[2] = mk4(F0, F0, s, F0);
    m[3] = mk4(F0, F0, F0, s);
    return m;
  endfunction

  task automatic load_beats(input mat4_t m, input int first, input int n, input bit gap);
    for (int j = first; j < first + n; j++) begin
      @(negedge clk);
      mat_col_in   = m[j];
      mat_valid_in = 1'b1;
      if (gap && j < first + n - 1) begin
        @(negedge clk);
        mat_valid_in = 1'b0;
      end
    end
    @(negedge clk);
    mat_valid_in = 1'b0;
  endtask

  task automatic send_vertex(input vec3_t v, output int acc, output bit ok);
    ok  = 1'b0;
    acc = 0;
    @(negedge clk);
    vertex_in       = v;
    vertex_valid_in = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (vertex_ready_out) begin
        ok  = 1'b1;
        acc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    vertex_valid_in = 1'b0;
  endtask

  task automatic wait_out(output int oc, output bit ok);
    ok = 1'b0;
    oc = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (valid_out) begin
        ok = 1'b1;
        oc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_checks++;
    if (vertex_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", vertex_ready_out); end
    n_checks++;
    if (vertex_out !== '0) begin n_fail++; $display("FAIL reset_vout: got %h want 0", vertex_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_identity();
    int acc, oc; bit ok; vec4_t e;
    load_beats(diag(F1), 0, 4, 1'b0);
    n_checks++;
    if (vertex_ready_out !== 1'b1) begin n_fail++; $display("FAIL ident_ready: got %b want 1", vertex_ready_out); end
    exp_q.push_back(mk4(F1, F2, F3, F1));
    send_vertex(mk3(F1, F2, F3), acc, ok);
    wait_out(oc, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ident_timeout: got no valid_out want valid_out"); end
    else if (vertex_out !== e) begin n_fail++; $display("FAIL ident_data: got %h want %h", vertex_out, e); end
    n_checks++;
    if (oc - acc != LAT) begin n_fail++; $display("FAIL ident_latency: got %0d want %0d", oc - acc, LAT); end
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || vertex_ready_out !== 1'b1) begin
      n_fail++; $display("FAIL ident_release: got valid=%b ready=%b want valid=0 ready=1", valid_out, vertex_ready_out);
    end
  endtask

  task automatic test_partial_load();
    int acc, oc; bit ok; vec4_t e;
    @(negedge clk); rst_in = 1'b1;
    @(negedge clk); rst_in = 1'b0;
    n_checks++;
    if (vertex_ready_out !== 1'b0) begin n_fail++; $display("FAIL pl_unloaded: got %b want 0", vertex_ready_out); end
    load_beats(diag(F2), 0, 2, 1'b0);
    @(negedge clk); rst_in = 1'b1;
    @(negedge clk); rst_in = 1'b0;
    n_checks++;
    if (vertex_ready_out !== 1'b0) begin n_fail++; $display("FAIL pl_after_rst: got %b want 0", vertex_ready_out); end
    load_beats(diag(F1), 0, 3, 1'b0);
    n_checks++;
    if (vertex_ready_out !== 1'b0) begin n_fail++; $display("FAIL pl_three_beats: got %b want 0", vertex_ready_out); end
    load_beats(diag(F1), 3, 1, 1'b0);
    n_checks++;
    if (vertex_ready_out !== 1'b1) begin n_fail++; $display("FAIL pl_four_beats: got %b want 1", vertex_ready_out); end
    exp_q.push_back(mk4(F1, F2, F3, F1));
    send_vertex(mk3(F1, F2, F3), acc, ok);
    wait_out(oc, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pl_timeout: got no valid_out want valid_out"); end
    else if (vertex_out !== e) begin n_fail++; $display("FAIL pl_data: got %h want %h", vertex_out, e); end
  endtask

  task automatic test_translation();
    int acc, oc; bit ok; vec4_t e; mat4_t m;
    m    = diag(F1);
    m[3] = mk4(F5, F0, F0, F1);
    load_beats(m, 0, 4, 1'b1);
    exp_q.push_back(mk4(F6, F0, F0, F1));
    send_vertex(mk3(F1, F0, F0), acc, ok);
    wait_out(oc, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL trans_timeout: got no valid_out want valid_out"); end
    else if (vertex_out !== e) begin n_fail++; $display("FAIL trans_data: got %h want %h", vertex_out, e); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, oc1, oc2; bit ok1, ok2, okw1, okw2; vec4_t e1, e2;
    exp_q.push_back(mk4(F6, F0, F0, F1));
    exp_q.push_back(mk4(F7, F2, F3, F1));
    send_vertex(mk3(F1, F0, F0), acc1, ok1);
    fork
      send_vertex(mk3(F2, F2, F3), acc2, ok2);
      begin
        wait_out(oc1, okw1);
        e1 = exp_q.pop_front();
        n_checks++;
        if (!okw1) begin n_fail++; $display("FAIL b2b_first_timeout: got no valid_out want valid_out"); end
        else if (vertex_out !== e1) begin n_fail++; $display("FAIL b2b_first_data: got %h want %h", vertex_out, e1); end
      end
    join
    wait_out(oc2, okw2);
    e2 = exp_q.pop_front();
    n_checks++;
    if (!okw2 || !ok2) begin n_fail++; $display("FAIL b2b_second_timeout: got ok=%b want 1", okw2 & ok2); end
    else if (vertex_out !== e2) begin n_fail++; $display("FAIL b2b_second_data: got %h want %h", vertex_out, e2); end
    n_checks++;
    if (acc2 - acc1 != LAT + 1) begin n_fail++; $display("FAIL b2b_interval: got %0d want %0d", acc2 - acc1, LAT + 1); end
    n_checks++;
    if (oc2 - acc2 != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", oc2 - acc2, LAT); end
  endtask

  task automatic test_backpressure();
    int acc, oc; bit ok; vec4_t e;
    load_beats(diag(F1), 0, 4, 1'b0);
    ready_in = 1'b0;
    exp_q.push_back(mk4(F1, F2, F3, F1));
    send_vertex(mk3(F1, F2, F3), acc, ok);
    wait_out(oc, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no valid_out want valid_out"); end
    else if (vertex_out !== e) begin n_fail++; $display("FAIL bp_data: got %h want %h", vertex_out, e); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (valid_out !== 1'b1 || vertex_out !== e || vertex_ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b out=%h want valid=1 ready=0 out=%h",
                 i, valid_out, vertex_ready_out, vertex_out, e);
      end
    end
    ready_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || vertex_ready_out !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", valid_out, vertex_ready_out);
    end
  endtask

  task automatic test_matrix_swap();
    int acc, oc, acc2, oc2; bit ok, okw, ok2, okw2; vec4_t e1, e2;
    exp_q.push_back(mk4(F1, F2, F3, F1));
    send_vertex(mk3(F1, F2, F3), acc, ok);
    repeat (3) @(negedge clk);
    fork
      load_beats(diag(F2), 0, 4, 1'b0);
      begin
        wait_out(oc, okw);
        e1 = exp_q.pop_front();
        n_checks++;
        if (!okw) begin n_fail++; $display("FAIL swap_old_timeout: got no valid_out want valid_out"); end
        else if (vertex_out !== e1) begin n_fail++; $display("FAIL swap_old_data: got %h want %h", vertex_out, e1); end
      end
    join
    exp_q.push_back(mk4(F2, F4, F6, F2));
    send_vertex(mk3(F1, F2, F3), acc2, ok2);
    wait_out(oc2, okw2);
    e2 = exp_q.pop_front();
    n_checks++;
    if (!okw2 || !ok2) begin n_fail++; $display("FAIL swap_new_timeout: got ok=%b want 1", okw2 & ok2); end
    else if (vertex_out !== e2) begin n_fail++; $display("FAIL swap_new_data: got %h want %h", vertex_out, e2); end
  endtask

  task automatic test_reset_issue();
    int acc, oc; bit ok, okw, seen; vec4_t e;
    send_vertex(mk3(F1, F2, F3), acc, ok);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | valid_out;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rsti_valid_seen: got %b want 0", seen); end
    n_checks++;
    if (vertex_ready_out !== 1'b0 || vertex_out !== '0) begin
      n_fail++; $display("FAIL rsti_state: got ready=%b out=%h want ready=0 out=0", vertex_ready_out, vertex_out);
    end
    load_beats(diag(F1), 0, 4, 1'b0);
    exp_q.push_back(mk4(F3, F0, F0, F1));
    send_vertex(mk3(F3, F0, F0), acc, ok);
    wait_out(oc, okw);
    e = exp_q.pop_front();
    n_checks++;
    if (!okw || !ok) begin n_fail++; $display("FAIL rsti_next_timeout: got ok=%b want 1", okw & ok); end
    else if (vertex_out !== e) begin n_fail++; $display("FAIL rsti_next_data: got %h want %h", vertex_out, e); end
  endtask

  initial begin
    rst_in          = 1'b1;
    mat_valid_in    = 1'b0;
    mat_col_in      = '0;
    vertex_valid_in = 1'b0;
    vertex_in       = '0;
    ready_in        = 1'b1;
    test_reset();
    test_identity();
    test_partial_load();
    test_translation();
    test_back_to_back();
    test_backpressure();
    test_matrix_swap();
    test_reset_issue();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
